ex_issue_scheduler: RTL and testbench

//  Issue controller in front of the execute stage. Accepts decoded ops on a valid/ready

---
 rtl/ex_issue_scheduler_if.sv | 36 +++
 rtl/ex_issue_scheduler.sv | 160 ++++++++++++++++
 tb/tb_ex_issue_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_issue_scheduler_if.sv
// Decode-to-execute handshake plus execute/writeback outputs of the issue scheduler.
// The slave modport is the scheduler side; master is the decode/observer side.
interface ex_issue_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [4:0]       in_rd;
    logic [3:0]       in_alu_ctrl;
    logic [15:0]      in_imm;
    logic             in_reg_write;
    logic             ex_valid;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic [3:0]       ex_alu_ctrl;
    logic [15:0]      ex_imm;
    logic             ex_reg_write;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_alu_ctrl, in_imm, in_reg_write,
        input  in_ready, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl, ex_imm,
        input  ex_reg_write, wb_valid, wb_rd, stall_count
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_alu_ctrl, in_imm, in_reg_write,
        output in_ready, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl, ex_imm,
        output ex_reg_write, wb_valid, wb_rd, stall_count
    );
endinterface

// File: rtl/ex_issue_scheduler.sv
// Issue controller: busy-scoreboard hazard stalls, jump hold-off, registered
// execute-stage outputs and a LAT-deep retire pipe producing the writeback pulse.
module ex_issue_scheduler #(
    parameter int LAT   = 3,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ex_issue_scheduler_if.slave   bus
);
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_JUMP = 4'd3;
    localparam int         JCNT_W  = 4;

    typedef enum logic {S_IDLE, S_JWAIT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [JCNT_W-1:0]  r_jcnt;
    logic [JCNT_W-1:0]  w_jcnt_nxt;
    logic [31:0]        r_busy;
    logic [31:0]        w_busy_set;
    logic [31:0]        w_busy_clr;
    logic [LAT-1:0]     r_ret_vld_p;
    logic [LAT-1:0]     r_ret_wr_p;
    logic [4:0]         r_ret_rd_p [LAT];
    logic               r_ex_vld_p1;
    logic [4:0]         r_ex_rs1_p1;
    logic [4:0]         r_ex_rs2_p1;
    logic [4:0]         r_ex_rd_p1;
    logic [3:0]         r_ex_ctrl_p1;
    logic [15:0]        r_ex_imm_p1;
    logic               r_ex_wr_p1;
    logic [CNT_W-1:0]   r_stall;
    logic               w_legal;
    logic               w_rs1_use;
    logic               w_rs2_use;
    logic               w_hazard;
    logic               w_ready;
    logic               w_accept;
    logic               w_issue;

    // Hazards look only at the registered scoreboard; bit 0 is never set.
    always_comb begin
        w_legal   = (bus.in_alu_ctrl == OP_ADD) || (bus.in_alu_ctrl == OP_ADDI) ||
                    (bus.in_alu_ctrl == OP_JUMP);
        w_rs1_use = (bus.in_alu_ctrl == OP_ADD) || (bus.in_alu_ctrl == OP_ADDI);
        w_rs2_use = (bus.in_alu_ctrl == OP_ADD);
        w_hazard  = (w_rs1_use && r_busy[bus.in_rs1]) ||
                    (w_rs2_use && r_busy[bus.in_rs2]) ||
                    (bus.in_reg_write && r_busy[bus.in_rd]);
        w_ready   = (r_state == S_IDLE) && !w_hazard;
        w_accept  = bus.in_valid && w_ready;
        w_issue   = w_accept && w_legal;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_jcnt_nxt  = r_jcnt;
        case (r_state)
            S_IDLE: begin
                if (w_issue && (bus.in_alu_ctrl == OP_JUMP)) begin
                    w_state_nxt = S_JWAIT;
                    w_jcnt_nxt  = JCNT_W'(LAT - 1);
                end
            end
            S_JWAIT: begin
                if (r_jcnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_jcnt_nxt = r_jcnt - JCNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_jcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_jcnt  <= w_jcnt_nxt;
        end
    end

    // A set and a clear of the same register never coincide thanks to the WAW stall.
    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        if (w_issue && bus.in_reg_write && (bus.in_rd != 5'd0)) begin
            w_busy_set[bus.in_rd] = 1'b1;
        end
        if (r_ret_vld_p[LAT-1] && r_ret_wr_p[LAT-1]) begin
            w_busy_clr[r_ret_rd_p[LAT-1]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy      <= '0;
            r_ret_vld_p <= '0;
            r_ret_wr_p  <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_ret_rd_p[i] <= '0;
            end
        end else begin
            r_busy         <= (r_busy & ~w_busy_clr) | w_busy_set;
            r_ret_vld_p[0] <= w_issue;
            r_ret_wr_p[0]  <= w_issue && bus.in_reg_write;
            r_ret_rd_p[0]  <= w_issue ? bus.in_rd : 5'd0;
            for (int i = 1; i < LAT; i++) begin
                r_ret_vld_p[i] <= r_ret_vld_p[i-1];
                r_ret_wr_p[i]  <= r_ret_wr_p[i-1];
                r_ret_rd_p[i]  <= r_ret_rd_p[i-1];
            end
        end
    end

    // Execute-stage register; illegal ops are accepted but never loaded here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_vld_p1  <= 1'b0;
            r_ex_rs1_p1  <= '0;
            r_ex_rs2_p1  <= '0;
            r_ex_rd_p1   <= '0;
            r_ex_ctrl_p1 <= '0;
            r_ex_imm_p1  <= '0;
            r_ex_wr_p1   <= 1'b0;
            r_stall      <= '0;
        end else begin
            r_ex_vld_p1 <= w_issue;
            if (w_issue) begin
                r_ex_rs1_p1  <= bus.in_rs1;
                r_ex_rs2_p1  <= bus.in_rs2;
                r_ex_rd_p1   <= bus.in_rd;
                r_ex_ctrl_p1 <= bus.in_alu_ctrl;
                r_ex_imm_p1  <= bus.in_imm;
                r_ex_wr_p1   <= bus.in_reg_write;
            end
            if (bus.in_valid && !w_ready && (r_stall != {CNT_W{1'b1}})) begin
                r_stall <= r_stall + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.ex_valid     = r_ex_vld_p1;
    assign bus.ex_rs1       = r_ex_rs1_p1;
    assign bus.ex_rs2       = r_ex_rs2_p1;
    assign bus.ex_rd        = r_ex_rd_p1;
    assign bus.ex_alu_ctrl  = r_ex_ctrl_p1;
    assign bus.ex_imm       = r_ex_imm_p1;
    assign bus.ex_reg_write = r_ex_wr_p1;
    assign bus.wb_valid     = r_ret_vld_p[LAT-1];
    assign bus.wb_rd        = r_ret_rd_p[LAT-1];
    assign bus.stall_count  = r_stall;
endmodule

// File: tb/tb_ex_issue_scheduler.sv
// Self-checking bench for ex_issue_scheduler: directed scenarios plus a randomized
// run against a time-based scoreboard model (register free-cycle and retire-cycle tables).
module tb_ex_issue_scheduler;
    localparam int LAT   = 3;
    localparam int CNT_W = 4;
    localparam int NREC  = 10;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic        wr;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ex_issue_scheduler_if #(.CNT_W(CNT_W)) sif ();
    ex_issue_scheduler #(.LAT(LAT), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(sif));

    int checks = 0;
    int errors = 0;

    op_t             seq_ops [4];
    logic [12:0]     obs [NREC];
    logic [CNT_W-1:0] obs_stall;
    logic            e_rdy  [NREC];
    logic            e_exv  [NREC];
    logic [4:0]      e_exrd [NREC];
    logic            e_wbv  [NREC];
    logic [4:0]      e_wbrd [NREC];

    function automatic op_t mk(input logic [3:0] c, input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] d, input logic w);
        op_t o;
        o.ctrl = c; o.rs1 = a; o.rs2 = b; o.rd = d; o.imm = {8'hA5, 3'b0, d}; o.wr = w;
        return o;
    endfunction

    task automatic drive(input op_t o, input logic v);
        sif.in_valid     = v;
        sif.in_alu_ctrl  = o.ctrl;
        sif.in_rs1       = o.rs1;
        sif.in_rs2       = o.rs2;
        sif.in_rd        = o.rd;
        sif.in_imm       = o.imm;
        sif.in_reg_write = o.wr;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        drive('0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic clear_exp;
        for (int k = 0; k < NREC; k++) begin
            e_rdy[k] = 1'b1; e_exv[k] = 1'b0; e_exrd[k] = '0; e_wbv[k] = 1'b0; e_wbrd[k] = '0;
        end
    endtask

    // Drive each op until accepted, then idle; record per-cycle observations.
    task automatic run_seq(input int nops);
        int idx = 0;
        for (int k = 0; k < NREC; k++) begin
            if (idx < nops) drive(seq_ops[idx], 1'b1);
            else drive('0, 1'b0);
            @(negedge clk);
            obs[k] = {sif.in_ready, sif.ex_valid, sif.ex_valid ? sif.ex_rd : 5'd0,
                      sif.wb_valid, sif.wb_valid ? sif.wb_rd : 5'd0};
            if (sif.in_valid && sif.in_ready) idx++;
            obs_stall = sif.stall_count;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        drive('0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (sif.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %b want 0", sif.ex_valid); end
        checks++; if (sif.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", sif.wb_valid); end
        checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", sif.in_ready); end
        checks++; if (sif.stall_count !== '0) begin errors++; $display("FAIL reset_stall got %0d want 0", sif.stall_count); end
        checks++;
        if ({sif.ex_rs1, sif.ex_rs2, sif.ex_rd, sif.ex_alu_ctrl, sif.ex_imm, sif.ex_reg_write, sif.wb_rd} !== '0) begin
            errors++;
            $display("FAIL reset_ex_fields got %h want 0",
                     {sif.ex_rs1, sif.ex_rs2, sif.ex_rd, sif.ex_alu_ctrl, sif.ex_imm, sif.ex_reg_write, sif.wb_rd});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        do_reset();
        seq_ops[0] = mk(4'd1, 5'd1, 5'd2, 5'd3, 1'b1);
        seq_ops[1] = mk(4'd1, 5'd1, 5'd2, 5'd4, 1'b1);
        run_seq(2);
        clear_exp();
        e_exv[1] = 1; e_exrd[1] = 5'd3; e_exv[2] = 1; e_exrd[2] = 5'd4;
        e_wbv[3] = 1; e_wbrd[3] = 5'd3; e_wbv[4] = 1; e_wbrd[4] = 5'd4;
        for (int k = 0; k < NREC; k++) begin
            checks++;
            if (obs[k] !== {e_rdy[k], e_exv[k], e_exrd[k], e_wbv[k], e_wbrd[k]}) begin
                errors++;
                $display("FAIL b2b cyc%0d got %b want %b", k, obs[k], {e_rdy[k], e_exv[k], e_exrd[k], e_wbv[k], e_wbrd[k]});
            end
        end
        checks++; if (obs_stall !== 4'd0) begin errors++; $display("FAIL b2b_stall got %0d want 0", obs_stall); end
    endtask

    task automatic test_raw;
        do_reset();
        seq_ops[0] = mk(4'd1, 5'd1, 5'd2, 5'd5, 1'b1);
        seq_ops[1] = mk(4'd2, 5'd5, 5'd0, 5'd8, 1'b1);
        run_seq(2);
        clear_exp();
        e_rdy[1] = 0; e_rdy[2] = 0; e_rdy[3] = 0;
        e_exv[1] = 1; e_exrd[1] = 5'd5; e_exv[5] = 1; e_exrd[5] = 5'd8;
        e_wbv[3] = 1; e_wbrd[3] = 5'd5; e_wbv[7] = 1; e_wbrd[7] = 5'd8;
        for (int k = 0; k < NREC; k++) begin
            checks++;
            if (obs[k] !== {e_rdy[k], e_exv[k], e_exrd[k], e_wbv[k], e_wbrd[k]}) begin
                errors++;
                $display("FAIL raw cyc%0d got %b want %b", k, obs[k], {e_rdy[k], e_exv[k], e_exrd[k], e_wbv[k], e_wbrd[k]});
            end
        end
        checks++; if (obs_stall !== 4'd3) begin errors++; $display("FAIL raw_stall got %0d want 3", obs_stall); end
    endtask

    task automatic test_zero_reg;
        do_reset();
        seq_ops[0] = mk(4'd1, 5'd1, 5'd2, 5'd0, 1'b1);
        seq_ops[1] = mk(4'd1, 5'd0, 5'd0, 5'd9, 1'b1);
        run_seq(2);
        clear_exp();
        e_exv[1] = 1; e_exrd[1] = 5'd0; e_exv[2] = 1; e_exrd[2] = 5'd9;
        e_wbv[3] = 1; e_wbrd[3] = 5'd0; e_wbv[4] = 1; e_wbrd[4] = 5'd9;
        for (int k = 0; k < NREC; k++) begin
            checks++;
            if (obs[k] !== {e_rdy[k], e_exv[k], e_exrd[k], e_wbv[k], e_wbrd[k]}) begin
                errors++;
                $display("FAIL zero_reg cyc%0d got %b want %b", k, obs[k], {e_rdy[k], e_exv[k], e_exrd[k], e_wbv[k], e_wbrd[k]});
            end
        end
        checks++; if (obs_stall !== 4'd0) begin errors++; $display("FAIL zero_reg_stall got %0d want 0", obs_stall); end
    endtask

    task automatic test_jump;
        do_reset();
        seq_ops[0] = mk(4'd3, 5'd0, 5'd0, 5'd31, 1'b1);
        seq_ops[1] = mk(4'd1, 5'd1, 5'd2, 5'd6, 1'b1);
        run_seq(2);
        clear_exp();
        e_rdy[1] = 0; e_rdy[2] = 0; e_rdy[3] = 0;
        e_exv[1] = 1; e_exrd[1] = 5'd31; e_exv[5] = 1; e_exrd[5] = 5'd6;
        e_wbv[3] = 1; e_wbrd[3] = 5'd31; e_wbv[7] = 1; e_wbrd[7] = 5'd6;
        for (int k = 0; k < NREC; k++) begin
            checks++;
            if (obs[k] !== {e_rdy[k], e_exv[k], e_exrd[k], e_wbv[k], e_wbrd[k]}) begin
                errors++;
                $display("FAIL jump cyc%0d got %b want %b", k, obs[k], {e_rdy[k], e_exv[k], e_exrd[k], e_wbv[k], e_wbrd[k]});
            end
        end
        checks++; if (obs_stall !== 4'd3) begin errors++; $display("FAIL jump_stall got %0d want 3", obs_stall); end
    endtask

    task automatic test_illegal;
        do_reset();
        seq_ops[0] = mk(4'd5, 5'd1, 5'd1, 5'd12, 1'b1);
        seq_ops[1] = mk(4'd1, 5'd12, 5'd12, 5'd13, 1'b1);
        run_seq(2);
        clear_exp();
        e_exv[2] = 1; e_exrd[2] = 5'd13; e_wbv[4] = 1; e_wbrd[4] = 5'd13;
        for (int k = 0; k < NREC; k++) begin
            checks++;
            if (obs[k] !== {e_rdy[k], e_exv[k], e_exrd[k], e_wbv[k], e_wbrd[k]}) begin
                errors++;
                $display("FAIL illegal cyc%0d got %b want %b", k, obs[k], {e_rdy[k], e_exv[k], e_exrd[k], e_wbv[k], e_wbrd[k]});
            end
        end
    endtask

    task automatic test_reset_midflight;
        do_reset();
        drive(mk(4'd1, 5'd1, 5'd2, 5'd7, 1'b1), 1'b1);
        @(posedge clk); #1;
        drive('0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(mk(4'd1, 5'd7, 5'd7, 5'd10, 1'b1), 1'b1);
        for (int k = 2; k < 7; k++) begin
            @(negedge clk);
            if (k == 2) begin
                checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", sif.in_ready); end
                checks++; if (sif.stall_count !== '0) begin errors++; $display("FAIL midrst_stall got %0d want 0", sif.stall_count); end
                checks++; if (sif.ex_valid !== 1'b0) begin errors++; $display("FAIL midrst_ex_valid got %b want 0", sif.ex_valid); end
            end
            checks++;
            if (k < 5 && sif.wb_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_wb cyc%0d got %b want 0", k, sif.wb_valid);
            end else if (k == 5 && {sif.wb_valid, sif.wb_rd} !== {1'b1, 5'd10}) begin
                errors++; $display("FAIL midrst_wb cyc%0d got %b/%0d want 1/10", k, sif.wb_valid, sif.wb_rd);
            end
            @(posedge clk); #1;
            drive('0, 1'b0);
        end
    endtask

    task automatic test_saturation;
        int want;
        do_reset();
        for (int k = 0; k < 24; k++) begin
            drive(mk(4'd3, 5'd0, 5'd0, 5'd0, 1'b0), 1'b1);
            @(negedge clk);
            want = k - (k + 3) / 4;
            if (want > 15) want = 15;
            checks++;
            if (sif.stall_count !== CNT_W'(want)) begin
                errors++; $display("FAIL sat cyc%0d got %0d want %0d", k, sif.stall_count, want);
            end
            @(posedge clk); #1;
        end
        drive('0, 1'b0);
    endtask

    task automatic test_random;
        int busy_until [32];
        int jump_until;
        int exp_stall;
        op_t exp_ex [int];
        logic [4:0] exp_wb [int];
        op_t o;
        op_t got;
        logic v, hz, mr, legal;
        int t, sel, c;
        do_reset();
        for (int r = 0; r < 32; r++) busy_until[r] = -1;
        jump_until = -1;
        exp_stall = 0;
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                c = $urandom_range(4, 16);
                o.ctrl = (c == 16) ? 4'd0 : 4'(c);
            end else if (sel < 3) o.ctrl = 4'd3;
            else if (sel < 11) o.ctrl = 4'd1;
            else o.ctrl = 4'd2;
            o.rs1 = 5'($urandom_range(0, 7));
            o.rs2 = 5'($urandom_range(0, 7));
            o.rd  = 5'($urandom_range(0, 7));
            o.imm = 16'($urandom);
            o.wr  = ($urandom_range(0, 3) != 0);
            v     = ($urandom_range(0, 3) != 0);
            drive(o, v);
            @(negedge clk);
            t = cyc;
            legal = (o.ctrl >= 4'd1) && (o.ctrl <= 4'd3);
            hz = (((o.ctrl == 4'd1) || (o.ctrl == 4'd2)) && t <= busy_until[o.rs1]) ||
                 ((o.ctrl == 4'd1) && t <= busy_until[o.rs2]) ||
                 (o.wr && t <= busy_until[o.rd]);
            mr = (t > jump_until) && !hz;
            checks++;
            if (sif.in_ready !== mr) begin errors++; $display("FAIL rnd_ready t%0d got %b want %b", t, sif.in_ready, mr); end
            checks++;
            if (sif.ex_valid !== exp_ex.exists(t)) begin
                errors++; $display("FAIL rnd_ex_valid t%0d got %b want %b", t, sif.ex_valid, exp_ex.exists(t));
            end else if (exp_ex.exists(t)) begin
                got = {sif.ex_alu_ctrl, sif.ex_rs1, sif.ex_rs2, sif.ex_rd, sif.ex_imm, sif.ex_reg_write};
                checks++;
                if (got !== exp_ex[t]) begin errors++; $display("FAIL rnd_ex_fields t%0d got %h want %h", t, got, exp_ex[t]); end
            end
            checks++;
            if (sif.wb_valid !== exp_wb.exists(t)) begin
                errors++; $display("FAIL rnd_wb_valid t%0d got %b want %b", t, sif.wb_valid, exp_wb.exists(t));
            end else if (exp_wb.exists(t)) begin
                checks++;
                if (sif.wb_rd !== exp_wb[t]) begin errors++; $display("FAIL rnd_wb_rd t%0d got %0d want %0d", t, sif.wb_rd, exp_wb[t]); end
            end
            checks++;
            if (sif.stall_count !== CNT_W'(exp_stall)) begin
                errors++; $display("FAIL rnd_stall t%0d got %0d want %0d", t, sif.stall_count, exp_stall);
            end
            if (v && mr && legal) begin
                exp_ex[t + 1] = o;
                exp_wb[t + LAT] = o.rd;
                if (o.wr && o.rd != 5'd0) busy_until[o.rd] = t + LAT;
                if (o.ctrl == 4'd3) jump_until = t + LAT;
            end
            if (v && !mr && exp_stall < 15) exp_stall++;
            @(posedge clk); #1;
        end
        drive('0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive('0, 1'b0);
        test_reset();
        test_back_to_back();
        test_raw();
        test_zero_reg();
        test_jump();
        test_illegal();
        test_reset_midflight();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
